rep3_tx: RTL and testbench

REP3_TX -- requirements
Module: rep3_tx

---
 rtl/rep3_tx.sv | 147 ++++++++++++++
 tb/tb_rep3_tx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rep3_tx.sv
// rtl/rep3_tx.sv - triple-repetition serial transmitter
// Each frame bit (start 0, LSB-first data, stop 1) is sent as three identical symbols.
module rep3_tx #(
  parameter int DATA_W      = 8,
  parameter int CLK_PER_SYM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(CLK_PER_SYM - 1);
  localparam logic [3:0] BIT_LAST   = 4'(DATA_W - 1);
  // The last clock of the stop bit is spent in IDLE as the done cycle, so a word
  // accepted there starts its start bit with no idle symbol between frames.
  localparam logic [1:0] STOP_REP_LAST   = (CLK_PER_SYM == 1) ? 2'd1 : 2'd2;
  localparam logic [7:0] STOP_TIMER_LAST = (CLK_PER_SYM == 1) ? 8'd0 : 8'(CLK_PER_SYM - 2);

  state_t            state_q, state_d;
  logic [7:0]        timer_q, timer_d;
  logic [1:0]        rep_q, rep_d;
  logic [3:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              in_ready_q, in_ready_d;
  logic              done_q, done_d;

  logic              sym_end;
  logic [DATA_W-1:0] shifted;

  always_comb begin
    sym_end    = (timer_q == TIMER_LAST);
    shifted    = shreg_q >> 1;
    state_d    = state_q;
    timer_d    = timer_q;
    rep_d      = rep_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    in_ready_d = in_ready_q;
    done_d     = 1'b0;

    if (state_q != IDLE) begin
      timer_d = sym_end ? 8'd0 : timer_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        timer_d    = 8'd0;
        rep_d      = 2'd0;
        bit_d      = 4'd0;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        in_ready_d = 1'b1;
        if (din_valid && in_ready_q) begin
          shreg_d    = din;
          state_d    = START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          in_ready_d = 1'b0;
        end
      end
      START: begin
        if (sym_end) begin
          if (rep_q == 2'd2) begin
            rep_d   = 2'd0;
            state_d = DATA;
            tx_d    = shreg_q[0];
          end else begin
            rep_d = rep_q + 2'd1;
          end
        end
      end
      DATA: begin
        if (sym_end) begin
          if (rep_q == 2'd2) begin
            rep_d   = 2'd0;
            shreg_d = shifted;
            if (bit_q == BIT_LAST) begin
              bit_d   = 4'd0;
              state_d = STOP;
              tx_d    = 1'b1;
            end else begin
              bit_d = bit_q + 4'd1;
              tx_d  = shifted[0];
            end
          end else begin
            rep_d = rep_q + 2'd1;
          end
        end
      end
      STOP: begin
        if (rep_q == STOP_REP_LAST && timer_q == STOP_TIMER_LAST) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          in_ready_d = 1'b1;
          tx_d       = 1'b1;
          timer_d    = 8'd0;
          rep_d      = 2'd0;
        end else if (sym_end) begin
          rep_d = rep_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= 8'd0;
      rep_q      <= 2'd0;
      bit_q      <= 4'd0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rep_q      <= rep_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign in_ready = in_ready_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rep3_tx.sv
// tb/tb_rep3_tx.sv - bench for rep3_tx
// Two instances: default timing (4 clocks/symbol) and 1 clock/symbol.
module tb_rep3_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din0 = 8'h00, din1 = 8'h00;
  logic       dv0 = 1'b0, dv1 = 1'b0;
  logic       rdy0, tx0, busy0, done0;
  logic       rdy1, tx1, busy1, done1;
  int         tests = 0;
  int         failed = 0;

  always #5 clk = ~clk;

  rep3_tx #(.DATA_W(8), .CLK_PER_SYM(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .din(din0), .din_valid(dv0),
    .in_ready(rdy0), .tx(tx0), .busy(busy0), .done(done0)
  );

  rep3_tx #(.DATA_W(8), .CLK_PER_SYM(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(dv1),
    .in_ready(rdy1), .tx(tx1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level of clock i of a frame: logical bit i/(3*cps) of {start, data LSB first, stop}.
  function automatic logic model_bit(input logic [7:0] w, input int i, input int cps);
    int lb;
    lb = i / (3 * cps);
    if (lb == 0) return 1'b0;
    if (lb == 9) return 1'b1;
    return w[lb-1];
  endfunction

  function automatic logic [3:0] outs(input int s);
    return (s == 0) ? {tx0, busy0, rdy0, done0} : {tx1, busy1, rdy1, done1};
  endfunction

  task automatic drive(input int s, input logic [7:0] d, input logic v);
    if (s == 0) begin din0 = d; dv0 = v; end
    else begin din1 = d; dv1 = v; end
  endtask

  task automatic offer(input int s, input logic [7:0] w);
    logic [3:0] o;
    @(negedge clk);
    drive(s, w, 1'b1);
    o = outs(s);
    chk("in_ready_offer", o[1], 1);
  endtask

  // Observes one frame after its acceptance edge, then majority-decodes the recorded line.
  task automatic frame(input int s, input logic [7:0] w, input bit hold, input logic [7:0] next_w,
                       input bit flip, input int poke_at, input logic [7:0] poke_w, input string tag);
    int         cps, len, bad_tx, bad_busy, bad_rdy, n_done, done_k, votes, rf;
    logic       symbuf [120];
    logic [3:0] o;
    logic [9:0] dec;
    logic       v;
    cps = (s == 0) ? 4 : 1;
    len = 30 * cps;
    bad_tx = 0; bad_busy = 0; bad_rdy = 0; n_done = 0; done_k = 0;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      o = outs(s);
      symbuf[k-1] = o[3];
      if (o[3] !== model_bit(w, k - 1, cps)) bad_tx++;
      if (o[2] !== (k < len)) bad_busy++;
      if (o[1] !== (k == len)) bad_rdy++;
      if (o[0] === 1'b1) begin n_done++; done_k = k; end
      if (k == 1 && !hold) drive(s, w, 1'b0);
      if (k == poke_at) drive(s, poke_w, 1'b1);
      if (poke_at > 0 && k == len - 1) drive(s, poke_w, 1'b0);
      if (hold && k == len) drive(s, next_w, 1'b1);
    end
    for (int b = 0; b < 10; b++) begin
      rf = flip ? int'($urandom_range(0, 2)) : 3;
      votes = 0;
      for (int r = 0; r < 3; r++) begin
        v = symbuf[(3 * b + r) * cps + cps / 2];
        if (r == rf) v = ~v;
        votes += (v === 1'b1) ? 1 : 0;
      end
      dec[b] = (votes >= 2);
    end
    chk({tag, "_tx_stream"}, bad_tx, 0);
    chk({tag, "_busy"}, bad_busy, 0);
    chk({tag, "_in_ready"}, bad_rdy, 0);
    chk({tag, "_done_count"}, n_done, 1);
    chk({tag, "_done_clock"}, done_k, len);
    chk({tag, "_dec_start"}, dec[0], 0);
    chk({tag, "_dec_stop"}, dec[9], 1);
    chk({tag, "_dec_data"}, dec[8:1], w);
  endtask

  initial begin
    logic [7:0] words [256];
    logic [7:0] nxt;
    logic [3:0] o;
    int         bad;

    drive(0, 8'h00, 1'b0);
    drive(1, 8'h00, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      o = outs(s);
      chk("reset_tx", o[3], 1);
      chk("reset_busy", o[2], 0);
      chk("reset_in_ready", o[1], 1);
      chk("reset_done", o[0], 0);
    end
    rst_n = 1'b1;

    offer(0, 8'hA5);
    frame(0, 8'hA5, 1'b0, 8'h00, 1'b0, 0, 8'h00, "a5");

    offer(1, 8'h00);
    frame(1, 8'h00, 1'b1, 8'hFF, 1'b0, 0, 8'h00, "b2b_00");
    frame(1, 8'hFF, 1'b0, 8'h00, 1'b0, 0, 8'h00, "b2b_ff");

    offer(0, 8'hC3);
    frame(0, 8'hC3, 1'b0, 8'h00, 1'b0, 30, 8'h3C, "mid_din");

    // Reset during DATA bit 4 (clocks 61..72 of a 4-clock-per-symbol frame).
    offer(0, 8'hA5);
    for (int k = 1; k <= 62; k++) begin
      @(negedge clk);
      if (k == 1) drive(0, 8'hA5, 1'b0);
    end
    o = outs(0);
    chk("pre_rst_busy", o[2], 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    o = outs(0);
    chk("rst_mid_tx", o[3], 1);
    chk("rst_mid_busy", o[2], 0);
    chk("rst_mid_in_ready", o[1], 1);
    chk("rst_mid_done", o[0], 0);
    bad = 0;
    for (int k = 0; k < 130; k++) begin
      @(negedge clk);
      o = outs(0);
      if (o[0] !== 1'b0 || o[3] !== 1'b1) bad++;
    end
    chk("rst_mid_quiet", bad, 0);
    offer(0, 8'h5A);
    frame(0, 8'h5A, 1'b0, 8'h00, 1'b0, 0, 8'h00, "after_rst");

    // din_valid in the same cycle as reset must not start a frame.
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 8'hFF, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 8'hFF, 1'b0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      o = outs(0);
      if (o[3] !== 1'b1 || o[2] !== 1'b0 || o[1] !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("rst_valid_no_frame", bad, 0);

    for (int i = 0; i < 256; i++) words[i] = 8'($urandom);
    offer(1, words[0]);
    for (int i = 0; i < 256; i++) begin
      nxt = 8'h00;
      if (i < 255) nxt = words[i+1];
      frame(1, words[i], i < 255, nxt, 1'b1, 0, 8'h00, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
